// File: rtl/tx_port_gate_arbiter_128_pkg.sv
// tx_gate_pkg: shared types and constants for the tx_port gate arbiter.
//   state_e          - arbiter FSM states
//   C_GATE_FLAG_BIT  - flag bit position for the default 128-bit gate word
//   LEN_LSB/OFF_LSB/LAST_BIT - header field offsets inside the gate payload
//   gate_width()     - gate word width (payload plus flag bit)
package tx_gate_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        END2 = 2'd3
    } state_e;

    localparam int C_DATA_WIDTH_DFLT = 128;
    localparam int C_GATE_FLAG_BIT   = C_DATA_WIDTH_DFLT;

    // Header payload layout: {64'd0, len[31:0], off[30:0], last}
    localparam int LEN_LSB  = 32;
    localparam int OFF_LSB  = 1;
    localparam int LAST_BIT = 0;

    function automatic int gate_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/tx_port_gate_arbiter_128_if.sv
// Bus between the channel gates, the arbiter and the TX formatting engine.
//   master: arbiter side (drives pops, header/data presentation, completion)
//   slave : environment side (gate heads/empties, downstream ready)
interface tx_port_gate_arbiter_128_if #(
    parameter int C_NUM_CHNL   = 4,
    parameter int C_DATA_WIDTH = 128,
    parameter int C_CHNL_W     = (C_NUM_CHNL > 1) ? $clog2(C_NUM_CHNL) : 1
);
    logic [C_NUM_CHNL*(C_DATA_WIDTH+1)-1:0] GATE_RD_DATA;
    logic [C_NUM_CHNL-1:0]                  GATE_RD_EMPTY;
    logic [C_NUM_CHNL-1:0]                  GATE_RD_EN;
    logic                                   TXN_VALID;
    logic                                   TXN_READY;
    logic [C_CHNL_W-1:0]                    TXN_CHNL;
    logic [31:0]                            TXN_LEN;
    logic [30:0]                            TXN_OFF;
    logic                                   TXN_LAST;
    logic [C_DATA_WIDTH-1:0]                DATA;
    logic                                   DATA_VALID;
    logic                                   DATA_READY;
    logic                                   TXN_DONE;
    logic [31:0]                            TXN_WORDS;
    logic                                   PROTO_ERR;

    modport master (
        input  GATE_RD_DATA, GATE_RD_EMPTY, TXN_READY, DATA_READY,
        output GATE_RD_EN, TXN_VALID, TXN_CHNL, TXN_LEN, TXN_OFF, TXN_LAST,
               DATA, DATA_VALID, TXN_DONE, TXN_WORDS, PROTO_ERR
    );

    modport slave (
        output GATE_RD_DATA, GATE_RD_EMPTY, TXN_READY, DATA_READY,
        input  GATE_RD_EN, TXN_VALID, TXN_CHNL, TXN_LEN, TXN_OFF, TXN_LAST,
               DATA, DATA_VALID, TXN_DONE, TXN_WORDS, PROTO_ERR
    );

endinterface

// File: rtl/tx_port_gate_arbiter_128_rr_pick.sv
// tx_port_gate_rr_pick: combinational round-robin picker.
//   req - request vector, one bit per gate
//   ptr - highest-priority index this round
//   vld - at least one request present
//   idx - first requesting index at or after ptr, wrapping modulo N
module tx_port_gate_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         vld,
    output logic [W-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest requester is the
    // last one written and therefore wins.
    always_comb begin
        int c;
        c   = 0;
        vld = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (req[c]) begin
                vld = 1'b1;
                idx = W'(c);
            end
        end
    end

endmodule

// File: rtl/tx_port_gate_arbiter_128.sv
// tx_port_gate_arbiter_128: round-robin drain of the tx_port channel gates
// into one transmit path. A grant is held for a whole transaction (header,
// data words, two end markers).
//   CLK - gate read clock
//   RST - synchronous active-high reset
//   bus - master side: gate pops, header/data handshakes, completion/error
module tx_port_gate_arbiter_128
    import tx_gate_pkg::*;
#(
    parameter int C_NUM_CHNL   = 4,
    parameter int C_DATA_WIDTH = C_DATA_WIDTH_DFLT,
    parameter int C_CHNL_W     = (C_NUM_CHNL > 1) ? $clog2(C_NUM_CHNL) : 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    tx_port_gate_arbiter_128_if.master bus
);

    localparam int GW       = gate_width(C_DATA_WIDTH);
    localparam int FLAG_BIT = GW - 1;

    state_e              state_q, state_d;
    logic [C_CHNL_W-1:0] gnt_q, ptr_q, pick_idx, next_ptr;
    logic [31:0]         cnt_q;
    logic                pick_vld;

    logic [C_NUM_CHNL-1:0][GW-1:0] heads;
    logic [GW-1:0]                 head;
    logic                          flag, empty_g;
    logic                          pop, txn_valid, data_valid, done, perr;

    // Head-word mux: the granted gate's FIFO output feeds every field directly.
    assign heads   = bus.GATE_RD_DATA;
    assign head    = heads[gnt_q];
    assign flag    = head[FLAG_BIT];
    assign empty_g = bus.GATE_RD_EMPTY[gnt_q];

    tx_port_gate_rr_pick #(.N(C_NUM_CHNL), .W(C_CHNL_W)) u_pick (
        .req (~bus.GATE_RD_EMPTY),
        .ptr (ptr_q),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    assign next_ptr = (gnt_q == C_CHNL_W'(C_NUM_CHNL - 1)) ? '0 : gnt_q + 1'b1;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; an empty granted gate simply holds the state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pick_vld) state_d = HDR;
            HDR:  if (!empty_g && flag && bus.TXN_READY) state_d = DATA;
            DATA: if (!empty_g && flag) state_d = END2;
            END2: if (!empty_g) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Everything is forced low while RST is high so nothing
    // is popped in the reset cycle.
    always_comb begin
        pop        = 1'b0;
        txn_valid  = 1'b0;
        data_valid = 1'b0;
        done       = 1'b0;
        perr       = 1'b0;
        if (!RST && !empty_g) begin
            case (state_q)
                HDR: begin
                    if (flag) begin
                        txn_valid = 1'b1;
                        pop       = bus.TXN_READY;
                    end else begin
                        // stray data word where a header belongs: discard it
                        pop  = 1'b1;
                        perr = 1'b1;
                    end
                end
                DATA: begin
                    if (!flag) begin
                        data_valid = 1'b1;
                        pop        = bus.DATA_READY;
                    end else begin
                        pop = 1'b1;  // first end marker, no handshake
                    end
                end
                END2: begin
                    if (flag) begin
                        pop  = 1'b1;
                        done = 1'b1;
                    end else begin
                        perr = 1'b1;  // left in place for the next grant
                    end
                end
                default: ;
            endcase
        end
    end

    // Grant, round-robin pointer and word counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            gnt_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            if (state_q == IDLE && pick_vld) gnt_q <= pick_idx;
            if (done) ptr_q <= next_ptr;
            // Cleared on any exit from END2 so an aborted transaction does
            // not leak its count into the next one.
            if (data_valid && bus.DATA_READY)   cnt_q <= cnt_q + 32'd1;
            else if (state_q == END2 && !empty_g) cnt_q <= '0;
        end
    end

    assign bus.GATE_RD_EN = pop ? (C_NUM_CHNL'(1) << gnt_q) : '0;
    assign bus.TXN_VALID  = txn_valid;
    assign bus.TXN_CHNL   = gnt_q;
    assign bus.TXN_LEN    = head[LEN_LSB +: 32];
    assign bus.TXN_OFF    = head[OFF_LSB +: 31];
    assign bus.TXN_LAST   = head[LAST_BIT];
    assign bus.DATA       = head[C_DATA_WIDTH-1:0];
    assign bus.DATA_VALID = data_valid;
    assign bus.TXN_DONE   = done;
    assign bus.TXN_WORDS  = cnt_q;
    assign bus.PROTO_ERR  = perr;

endmodule

// File: tb/tb_tx_port_gate_arbiter_128.sv
module tb_tx_port_gate_arbiter_128;
    localparam int NC = 4;
    localparam int DW = 128;
    localparam int GW = DW + 1;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    tx_port_gate_arbiter_128_if #(.C_NUM_CHNL(NC), .C_DATA_WIDTH(DW)) bus ();
    tx_port_gate_arbiter_128 #(.C_NUM_CHNL(NC), .C_DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // kind: 0 header accepted, 1 data beat accepted, 2 transaction done
    typedef struct { int kind; int chnl; logic [127:0] val; } ev_t;
    typedef struct { int prev; logic [NC-1:0] mask; int exp_chnl; } rr_vec_t;

    logic [GW-1:0] fifo [NC][$];
    ev_t           exp_q [$];
    rr_vec_t       vt [8];
    int            checks = 0, failures = 0;
    bit            mon_on;
    bit            tog;
    int            rdy_mode;  // 0 both high, 1 random, 2 data toggles, 3 manual
    int            cnt_tv, cnt_dv, cnt_dpop, cnt_pop, cnt_done, cnt_perr;
    logic [NC-1:0] last_en;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic update_gates();
        logic [NC-1:0][GW-1:0] d;
        logic [NC-1:0]         e;
        for (int g = 0; g < NC; g++) begin
            e[g] = (fifo[g].size() == 0);
            d[g] = e[g] ? '0 : fifo[g][0];
        end
        bus.GATE_RD_EMPTY = e;
        bus.GATE_RD_DATA  = d;
    endtask

    task automatic observe(input int kind, input int ch, input logic [127:0] v);
        ev_t e;
        chk("stream_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_chnl", ch, e.chnl);
            chk("ev_val", v, e.val);
        end
    endtask

    // One clock: set ready, present gate heads, sample and check away from
    // the edge, then apply the pops the DUT issued at the edge.
    task automatic cyc();
        logic [NC-1:0] en;
        logic tv, dv;
        case (rdy_mode)
            0: begin bus.TXN_READY = 1'b1; bus.DATA_READY = 1'b1; end
            1: begin
                bus.TXN_READY  = ($urandom_range(0, 3) != 0);
                bus.DATA_READY = ($urandom_range(0, 2) != 0);
            end
            2: begin bus.TXN_READY = 1'b1; bus.DATA_READY = tog; tog = ~tog; end
            default: ;
        endcase
        update_gates();
        #1;
        en = bus.GATE_RD_EN; tv = bus.TXN_VALID; dv = bus.DATA_VALID;
        last_en = en;
        chk("valid_excl", tv & dv, 0);
        chk("en_onehot", $countones(en) <= 1, 1);
        chk("en_nonempty", en & bus.GATE_RD_EMPTY, 0);
        if (tv || dv) chk("valid_gate_nonempty", bus.GATE_RD_EMPTY[bus.TXN_CHNL], 0);
        if ((tv && !bus.TXN_READY) || (dv && !bus.DATA_READY)) chk("en_no_ready", en, 0);
        if (tv) cnt_tv++;
        if (dv) cnt_dv++;
        if (dv && en != 0) cnt_dpop++;
        if (bus.TXN_DONE) cnt_done++;
        if (bus.PROTO_ERR) cnt_perr++;
        if (mon_on) begin
            if (tv && bus.TXN_READY)
                observe(0, bus.TXN_CHNL, {64'd0, bus.TXN_LEN, bus.TXN_OFF, bus.TXN_LAST});
            if (dv && bus.DATA_READY) observe(1, bus.TXN_CHNL, bus.DATA);
            if (bus.TXN_DONE) observe(2, bus.TXN_CHNL, 128'(bus.TXN_WORDS));
        end
        @(posedge CLK);
        for (int g = 0; g < NC; g++)
            if (en[g] && fifo[g].size() > 0) begin
                void'(fifo[g].pop_front());
                cnt_pop++;
            end
        @(negedge CLK);
    endtask

    task automatic push_hdr(input int g, input logic [31:0] len, input logic [30:0] off,
                            input logic last, input bit to_exp);
        fifo[g].push_back({1'b1, 64'd0, len, off, last});
        if (to_exp) exp_q.push_back('{0, g, {64'd0, len, off, last}});
    endtask

    task automatic push_data(input int g, input bit to_exp);
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        fifo[g].push_back({1'b0, w});
        if (to_exp) exp_q.push_back('{1, g, w});
    endtask

    task automatic push_end(input int g, input int nw, input bit to_exp);
        fifo[g].push_back({1'b1, 128'd0});
        fifo[g].push_back({1'b1, 128'd0});
        if (to_exp) exp_q.push_back('{2, g, 128'(nw)});
    endtask

    task automatic add_txn(input int g, input int nw, input logic [31:0] len,
                           input logic [30:0] off, input logic last, input bit to_exp);
        push_hdr(g, len, off, last, to_exp);
        for (int i = 0; i < nw; i++) push_data(g, to_exp);
        push_end(g, nw, to_exp);
    endtask

    task automatic run_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            cyc();
            n++;
        end
        chk("drain_in_budget", exp_q.size(), 0);
        repeat (3) cyc();
    endtask

    task automatic do_reset();
        RST = 1'b1; rdy_mode = 3;
        bus.TXN_READY = 1'b0; bus.DATA_READY = 1'b0;
        cyc();
        chk("rst_no_pop", last_en, 0);
        for (int g = 0; g < NC; g++) fifo[g].delete();
        exp_q.delete();
        RST = 1'b0;
        cnt_tv = 0; cnt_dv = 0; cnt_dpop = 0; cnt_pop = 0; cnt_done = 0; cnt_perr = 0;
        update_gates();
        #1;
        chk("rst_ctrl", {bus.GATE_RD_EN, bus.TXN_VALID, bus.DATA_VALID, bus.TXN_DONE, bus.PROTO_ERR}, 0);
        chk("rst_words", bus.TXN_WORDS, 0);
        chk("rst_chnl", bus.TXN_CHNL, 0);
        chk("rst_fields", {bus.TXN_LEN, bus.TXN_OFF, bus.TXN_LAST}, 0);
        chk("rst_data", bus.DATA, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rem [NC];
        int p, tot, g, n;
        RST = 1'b1; mon_on = 1'b0; rdy_mode = 3; tog = 1'b1;
        bus.TXN_READY = 1'b0; bus.DATA_READY = 1'b0;
        update_gates();
        @(negedge CLK);

        // Round-robin table: optionally finish a transaction on 'prev' to set
        // ptr=prev+1, then raise several gates together and read the winner.
        vt[0] = '{-1, 4'b0101, 0};
        vt[1] = '{-1, 4'b0100, 2};
        vt[2] = '{ 2, 4'b1111, 3};
        vt[3] = '{ 2, 4'b0111, 0};
        vt[4] = '{ 2, 4'b0110, 1};
        vt[5] = '{ 0, 4'b1001, 3};
        vt[6] = '{ 3, 4'b1100, 2};
        vt[7] = '{ 1, 4'b0011, 0};
        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (vt[i].prev >= 0) begin
                add_txn(vt[i].prev, 0, 32'd1, 31'd0, 1'b0, 1'b1);
                mon_on = 1'b1; rdy_mode = 0;
                run_drain(20);
                mon_on = 1'b0;
            end
            rdy_mode = 3; bus.TXN_READY = 1'b0; bus.DATA_READY = 1'b0;
            for (int k = 0; k < NC; k++)
                if (vt[i].mask[k]) push_hdr(k, 32'd4, 31'd0, 1'b1, 1'b0);
            cyc();
            update_gates();
            #1;
            chk("rr_valid", bus.TXN_VALID, 1);
            chk("rr_chnl", bus.TXN_CHNL, vt[i].exp_chnl);
        end

        // Single gate, 2 data words, ready held high
        do_reset(); mon_on = 1'b1; rdy_mode = 0;
        add_txn(0, 2, 32'd8, 31'd0, 1'b1, 1'b1);
        run_drain(20);
        chk("t1_tv_cycles", cnt_tv, 1);
        chk("t1_dv_cycles", cnt_dv, 2);
        chk("t1_pops", cnt_pop, 5);
        chk("t1_done", cnt_done, 1);

        // Zero-length transaction
        do_reset(); mon_on = 1'b1; rdy_mode = 0;
        add_txn(1, 0, 32'h0000_0100, 31'h55, 1'b0, 1'b1);
        run_drain(20);
        chk("t2_tv_cycles", cnt_tv, 1);
        chk("t2_no_dv", cnt_dv, 0);
        chk("t2_done", cnt_done, 1);

        // Gates 0 and 2 pending together: gate 0 drains completely first
        do_reset(); mon_on = 1'b1; rdy_mode = 0;
        add_txn(0, 3, 32'd48, 31'd7, 1'b0, 1'b1);
        add_txn(2, 2, 32'd32, 31'd9, 1'b1, 1'b1);
        run_drain(40);
        chk("t3_done", cnt_done, 2);

        // DATA_READY toggling over a 4-word payload
        do_reset(); mon_on = 1'b1; rdy_mode = 2; tog = 1'b1;
        add_txn(0, 4, 32'd64, 31'd3, 1'b1, 1'b1);
        run_drain(40);
        chk("t4_data_pops", cnt_dpop, 4);
        chk("t4_pops", cnt_pop, 7);

        // Gate 0 empties mid-payload for 10 cycles while gate 1 waits
        do_reset(); mon_on = 1'b1; rdy_mode = 0;
        push_hdr(0, 32'd64, 31'h10, 1'b0, 1'b1);
        push_data(0, 1'b1); push_data(0, 1'b1);
        push_hdr(1, 32'd5, 31'd0, 1'b1, 1'b0);
        push_end(1, 0, 1'b0);
        run_drain(20);
        cnt_tv = 0;
        repeat (10) cyc();
        chk("t5_gap_no_hdr", cnt_tv, 0);
        update_gates();
        #1;
        chk("t5_gap_gnt", bus.TXN_CHNL, 0);
        push_data(0, 1'b1); push_data(0, 1'b1);
        push_end(0, 4, 1'b1);
        exp_q.push_back('{0, 1, {64'd0, 32'd5, 31'd0, 1'b1}});
        exp_q.push_back('{2, 1, 128'd0});
        run_drain(30);
        chk("t5_done", cnt_done, 2);

        // Stray data word at the head while expecting a header
        do_reset(); mon_on = 1'b1; rdy_mode = 0;
        fifo[0].push_back({1'b0, 128'hdead_beef});
        add_txn(0, 1, 32'd16, 31'd2, 1'b1, 1'b1);
        run_drain(20);
        chk("t6_perr", cnt_perr, 1);
        chk("t6_pops", cnt_pop, 5);

        // Reset mid-DATA after ptr has moved to 2
        do_reset(); mon_on = 1'b1; rdy_mode = 0;
        add_txn(1, 0, 32'd2, 31'd0, 1'b1, 1'b1);
        run_drain(20);
        mon_on = 1'b0;
        add_txn(2, 4, 32'd64, 31'd0, 1'b1, 1'b0);
        n = 0;
        while (cnt_dv < 2 && n < 20) begin
            cyc();
            n++;
        end
        chk("t7_in_data", cnt_dv >= 2, 1);
        do_reset();
        rdy_mode = 3; bus.TXN_READY = 1'b0;
        push_hdr(3, 32'd4, 31'd0, 1'b1, 1'b0);
        push_hdr(0, 32'd4, 31'd0, 1'b1, 1'b0);
        cyc();
        update_gates();
        #1;
        chk("t7_valid", bus.TXN_VALID, 1);
        chk("t7_ptr0_chnl", bus.TXN_CHNL, 0);

        // Random rounds: all gates preloaded, service order from the rule
        // "lowest pending gate at or after ptr, then ptr = winner + 1".
        for (int r = 0; r < 4; r++) begin
            do_reset(); mon_on = 1'b1;
            tot = 0;
            for (int k = 0; k < NC; k++) begin
                rem[k] = $urandom_range(0, 3);
                tot += rem[k];
            end
            p = 0;
            while (tot > 0) begin
                g = -1;
                for (int k = 0; k < NC; k++)
                    if (g < 0 && rem[(p + k) % NC] > 0) g = (p + k) % NC;
                add_txn(g, $urandom_range(0, 5), $urandom, 31'($urandom), 1'($urandom), 1'b1);
                rem[g]--; tot--;
                p = (g + 1) % NC;
            end
            rdy_mode = 1;
            run_drain(2000);
            chk("rand_no_perr", cnt_perr, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
